// File: rtl/vga_pkg.sv
// Shared timing defaults, counter width and colour type for the VGA scan-out slice.
package vga_pkg;

   localparam int CNT_W           = 10;
   localparam int H_ACTIVE_DEF    = 640;
   localparam int H_FP_DEF        = 16;
   localparam int H_SYNC_DEF      = 96;
   localparam int H_BP_DEF        = 48;
   localparam int V_ACTIVE_DEF    = 480;
   localparam int V_FP_DEF        = 10;
   localparam int V_SYNC_DEF      = 2;
   localparam int V_BP_DEF        = 33;
   localparam int PIX_LATENCY_DEF = 2;

   localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
   localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
   localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb12_t;

   function automatic logic in_window(input logic [CNT_W-1:0] val,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with async reset and a synchronous flush.
module vga_delay_line #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [DEPTH-1:0][WIDTH-1:0] stage_r;

   // Shift towards the tail; a flush empties every stage at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_r <= '0;
      end else if (clr) begin
         stage_r <= '0;
      end else begin
         for (int i = DEPTH - 1; i > 0; i--) begin
            stage_r[i] <= stage_r[i-1];
         end
         stage_r[0] <= din;
      end
   end

   assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_scan_out.sv
// 640x480@60 scan engine: pixel requests by (x,y), colour capture and sync realignment.
module vga_scan_out
   import vga_pkg::*;
#(
   parameter int H_ACTIVE    = H_ACTIVE_DEF,
   parameter int H_FP        = H_FP_DEF,
   parameter int H_SYNC      = H_SYNC_DEF,
   parameter int H_BP        = H_BP_DEF,
   parameter int V_ACTIVE    = V_ACTIVE_DEF,
   parameter int V_FP        = V_FP_DEF,
   parameter int V_SYNC      = V_SYNC_DEF,
   parameter int V_BP        = V_BP_DEF,
   parameter int PIX_LATENCY = PIX_LATENCY_DEF
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic             enable,
   output logic             pix_req,
   output logic [CNT_W-1:0] pix_x,
   output logic [CNT_W-1:0] pix_y,
   input  logic [11:0]      pix_rgb,
   output logic             frame_tick,
   output logic             vga_conduit_CLK,
   output logic             vga_conduit_HS,
   output logic             vga_conduit_VS,
   output logic             vga_conduit_BLANK,
   output logic             vga_conduit_SYNC,
   output logic [3:0]       vga_conduit_R,
   output logic [3:0]       vga_conduit_G,
   output logic [3:0]       vga_conduit_B
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_ACT_C   = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_C   = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_LAST_C  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST_C  = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [CNT_W-1:0] h_cnt_r;
   logic [CNT_W-1:0] v_cnt_r;
   logic             pix_req_s;
   logic             hs_raw_s;
   logic             vs_raw_s;
   logic             tick_s;
   logic [2:0]       dly_in_s;
   logic [2:0]       dly_out_s;
   logic             hs_r;
   logic             vs_r;
   logic             blank_r;
   logic             tick_r;
   rgb12_t           rgb_r;

   // Scan counters: parked at the origin while disabled, wrap at the frame end
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         h_cnt_r <= {CNT_W{1'b0}};
         v_cnt_r <= {CNT_W{1'b0}};
      end else if (!enable) begin
         h_cnt_r <= {CNT_W{1'b0}};
         v_cnt_r <= {CNT_W{1'b0}};
      end else if (h_cnt_r == H_LAST_C) begin
         h_cnt_r <= {CNT_W{1'b0}};
         v_cnt_r <= (v_cnt_r == V_LAST_C) ? {CNT_W{1'b0}} : v_cnt_r + 10'd1;
      end else begin
         h_cnt_r <= h_cnt_r + 10'd1;
      end
   end

   // Raw timing flags decoded from the counters, gated by enable
   always_comb begin
      pix_req_s = enable && (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
      hs_raw_s  = enable && in_window(h_cnt_r, H_SYNC_LO, H_SYNC_HI);
      vs_raw_s  = enable && in_window(v_cnt_r, V_SYNC_LO, V_SYNC_HI);
      tick_s    = enable && (h_cnt_r == {CNT_W{1'b0}}) && (v_cnt_r == V_ACT_C);
      dly_in_s  = {hs_raw_s, vs_raw_s, pix_req_s};
   end

   // Syncs and the active flag wait out the renderer latency before meeting the colour
   vga_delay_line #(
      .WIDTH (3),
      .DEPTH (PIX_LATENCY)
   ) u_delay (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .clr   (~enable),
      .din   (dly_in_s),
      .dout  (dly_out_s)
   );

   // Pin register: colour is only trusted while the delayed active flag is set
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         hs_r    <= 1'b1;
         vs_r    <= 1'b1;
         blank_r <= 1'b0;
         rgb_r   <= 12'h000;
         tick_r  <= 1'b0;
      end else begin
         hs_r    <= ~dly_out_s[2];
         vs_r    <= ~dly_out_s[1];
         blank_r <= dly_out_s[0];
         rgb_r   <= dly_out_s[0] ? rgb12_t'(pix_rgb) : rgb12_t'(12'h000);
         tick_r  <= tick_s;
      end
   end

   assign pix_req           = pix_req_s;
   assign pix_x             = h_cnt_r;
   assign pix_y             = v_cnt_r;
   assign frame_tick        = tick_r;
   assign vga_conduit_CLK   = clk_clk;
   assign vga_conduit_HS    = hs_r;
   assign vga_conduit_VS    = vs_r;
   assign vga_conduit_BLANK = blank_r;
   assign vga_conduit_SYNC  = 1'b0;
   assign vga_conduit_R     = rgb_r.r;
   assign vga_conduit_G     = rgb_r.g;
   assign vga_conduit_B     = rgb_r.b;

endmodule
